// File: rtl/aqua_level_ctrl.sv
// Water-level controller: polls N_SENS echo channels, aggregates valid readings, classifies level with hysteresis and confirmation.
// Latency: one evaluation per PERIOD_CYC window; meas_done is waited on per channel up to TIMEOUT_CYC cycles.
module aqua_level_ctrl #(
    parameter int N_SENS      = 3,
    parameter int DW          = 12,
    parameter int TIMEOUT_CYC = 1500000,
    parameter int PERIOD_CYC  = 50000000,
    parameter int SPREAD      = 20,
    parameter int HYST        = 5,
    parameter int CONFIRM     = 2,
    localparam int SW = (N_SENS > 1) ? $clog2(N_SENS) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          iniciar,
    input  logic          manual_abre,
    input  logic [DW-1:0] th_crit,
    input  logic [DW-1:0] th_low,
    input  logic [DW-1:0] th_high,
    output logic          meas_start,
    output logic [SW-1:0] meas_sel,
    input  logic          meas_done,
    input  logic [DW-1:0] meas_dist,
    output logic [DW-1:0] level_dist,
    output logic [1:0]    level_class,
    output logic          abre_valvula,
    output logic          buzzer_baixa,
    output logic          buzzer_alta,
    output logic          fault,
    output logic          result_valid,
    output logic [3:0]    db_estado
);
    localparam logic [2:0] S_IDLE = 3'd0, S_START = 3'd1, S_WAIT = 3'd2, S_NEXT = 3'd3,
                           S_EVAL = 3'd4, S_CLASS = 3'd5, S_HOLD = 3'd6;
    localparam logic [1:0] C_CRIT = 2'b00, C_LOW = 2'b01, C_NORM = 2'b10, C_HIGH = 2'b11;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int CW = $clog2(PERIOD_CYC + 1);
    localparam int NW = $clog2(N_SENS + 1);
    localparam logic [DW:0] DMAX = {1'b0, {DW{1'b1}}};
    localparam logic [DW:0] HYS  = (DW+1)'(HYST);

    logic [2:0]    state_q, state_d;
    logic [SW-1:0] idx_q, idx_d;
    logic [TW-1:0] to_q, to_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [DW-1:0] min_q, min_d, max_q, max_d, dist_q, dist_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [3:0]    conf_q, conf_d;
    logic [1:0]    class_q, class_d;
    logic          fault_q, fault_d, auto_q, auto_d, start_q, start_d, rv_q, rv_d;
    logic          abre_q, bz_lo_q, bz_hi_q;

    logic [DW:0]   lo_x, hi_x, lo_w, hi_w, d_x;
    logic [1:0]    raw_cls, cand;
    logic [DW-1:0] spread;
    logic          sample_ok;

    // Interval of the current class, widened by HYST and clamped to the distance range.
    always_comb begin
        lo_x = '0;
        hi_x = DMAX;
        case (class_q)
            C_CRIT:  begin lo_x = {1'b0, th_crit}; hi_x = DMAX; end
            C_LOW:   begin lo_x = {1'b0, th_low};  hi_x = {1'b0, th_crit} - 1'b1; end
            C_NORM:  begin lo_x = {1'b0, th_high} + 1'b1; hi_x = {1'b0, th_low} - 1'b1; end
            default: begin lo_x = '0; hi_x = {1'b0, th_high}; end
        endcase
        lo_w = (lo_x > HYS) ? lo_x - HYS : '0;
        hi_w = (hi_x + HYS > DMAX) ? DMAX : hi_x + HYS;
        d_x  = {1'b0, dist_q};
        if (dist_q >= th_crit)     raw_cls = C_CRIT;
        else if (dist_q >= th_low) raw_cls = C_LOW;
        else if (dist_q <= th_high) raw_cls = C_HIGH;
        else                       raw_cls = C_NORM;
        cand      = (d_x >= lo_w && d_x <= hi_w) ? class_q : raw_cls;
        spread    = max_q - min_q;
        sample_ok = (meas_dist != '0) && (meas_dist != '1);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        to_d    = to_q;
        cyc_d   = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
        min_d   = min_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        conf_d  = conf_q;
        class_d = class_q;
        dist_d  = dist_q;
        fault_d = fault_q;
        auto_d  = auto_q;
        start_d = 1'b0;
        rv_d    = 1'b0;
        case (state_q)
            S_IDLE: if (iniciar) begin
                state_d = S_START; idx_d = '0; cyc_d = '0; start_d = 1'b1;
                min_d = '1; max_d = '0; cnt_d = '0;
            end
            S_START: begin
                state_d = S_WAIT;
                to_d    = '0;
            end
            S_WAIT: begin
                if (meas_done) begin
                    state_d = S_NEXT;
                    if (sample_ok) begin
                        if (meas_dist < min_q) min_d = meas_dist;
                        if (meas_dist > max_q) max_d = meas_dist;
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = S_NEXT;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_NEXT: begin
                if (idx_q < SW'(N_SENS - 1)) begin
                    idx_d = idx_q + 1'b1; state_d = S_START; start_d = 1'b1;
                end else begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d = S_CLASS;
                rv_d    = 1'b1;
                if (cnt_q == '0 || spread > DW'(SPREAD)) begin
                    fault_d = 1'b1;
                end else begin
                    fault_d = 1'b0;
                    dist_d  = min_q;
                end
            end
            S_CLASS: begin
                state_d = S_HOLD;
                if (!fault_q) begin
                    if (cand == class_q) begin
                        conf_d = '0;
                    end else if (conf_q + 4'd1 == 4'(CONFIRM)) begin
                        conf_d  = '0;
                        class_d = cand;
                        if (cand == C_CRIT || cand == C_LOW) auto_d = 1'b1;
                        else if (cand == C_HIGH)             auto_d = 1'b0;
                    end else begin
                        conf_d = conf_q + 4'd1;
                    end
                end
            end
            S_HOLD: if (cyc_q >= CW'(PERIOD_CYC - 1)) begin
                if (iniciar) begin
                    state_d = S_START; idx_d = '0; cyc_d = '0; start_d = 1'b1;
                    min_d = '1; max_d = '0; cnt_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;  idx_q  <= '0;  to_q   <= '0;  cyc_q   <= '0;
            min_q   <= '1;      max_q  <= '0;  cnt_q  <= '0;  conf_q  <= '0;
            class_q <= C_NORM;  dist_q <= '0;  fault_q <= 1'b0; auto_q <= 1'b0;
            start_q <= 1'b0;    rv_q   <= 1'b0;
            abre_q  <= 1'b0;    bz_lo_q <= 1'b0; bz_hi_q <= 1'b0;
        end else begin
            state_q <= state_d; idx_q  <= idx_d;  to_q    <= to_d;    cyc_q  <= cyc_d;
            min_q   <= min_d;   max_q  <= max_d;  cnt_q   <= cnt_d;   conf_q <= conf_d;
            class_q <= class_d; dist_q <= dist_d; fault_q <= fault_d; auto_q <= auto_d;
            start_q <= start_d; rv_q   <= rv_d;
            abre_q  <= auto_q | manual_abre;
            bz_lo_q <= (class_q == C_CRIT);
            bz_hi_q <= (class_q == C_HIGH);
        end
    end

    assign meas_start   = start_q;
    assign meas_sel     = idx_q;
    assign level_dist   = dist_q;
    assign level_class  = class_q;
    assign abre_valvula = abre_q;
    assign buzzer_baixa = bz_lo_q;
    assign buzzer_alta  = bz_hi_q;
    assign fault        = fault_q;
    assign result_valid = rv_q;
    assign db_estado    = {1'b0, state_q};
endmodule

// File: tb/tb_aqua_level_ctrl.sv
// Bench for aqua_level_ctrl: echo-engine responder plus an interval-based reference model of classification.
module tb_aqua_level_ctrl;
    localparam int DW = 12, NS = 3, TO = 20, PER = 200, SPR = 20, HY = 5, CF = 2;
    localparam int TH_C = 400, TH_L = 250, TH_H = 100;
    localparam int DMAXI = (1 << DW) - 1;

    logic          clock = 1'b0, reset = 1'b0, iniciar = 1'b0, manual_abre = 1'b0;
    logic          meas_done = 1'b0;
    logic [DW-1:0] meas_dist = '0;
    logic [DW-1:0] th_crit = DW'(TH_C), th_low = DW'(TH_L), th_high = DW'(TH_H);
    logic          meas_start, abre_valvula, buzzer_baixa, buzzer_alta, fault, result_valid;
    logic [1:0]    meas_sel, level_class;
    logic [DW-1:0] level_dist;
    logic [3:0]    db_estado;

    always #5 clock = ~clock;

    aqua_level_ctrl #(.N_SENS(NS), .DW(DW), .TIMEOUT_CYC(TO), .PERIOD_CYC(PER),
                      .SPREAD(SPR), .HYST(HY), .CONFIRM(CF)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .manual_abre(manual_abre),
        .th_crit(th_crit), .th_low(th_low), .th_high(th_high),
        .meas_start(meas_start), .meas_sel(meas_sel), .meas_done(meas_done), .meas_dist(meas_dist),
        .level_dist(level_dist), .level_class(level_class), .abre_valvula(abre_valvula),
        .buzzer_baixa(buzzer_baixa), .buzzer_alta(buzzer_alta), .fault(fault),
        .result_valid(result_valid), .db_estado(db_estado));

    int     n_tests = 0, n_fail = 0;
    longint tcnt = 0, prev_start = -1;
    int     rd [3];
    int     dl [3];
    int     m_class = 2, m_dist = 0, m_conf = 0, m_valve = 0, m_fault = 0;
    int     bases [10] = '{90, 100, 105, 240, 250, 255, 300, 395, 400, 410};

    task automatic tick();
        @(posedge clock);
        #1;
        tcnt++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int raw_cls(input int d);
        if (d >= TH_C) return 0;
        if (d >= TH_L) return 1;
        if (d <= TH_H) return 3;
        return 2;
    endfunction

    // Is d inside class c's interval, stretched by HY on each side?
    function automatic bit in_band(input int c, input int d);
        int lo, hi;
        case (c)
            0:       begin lo = TH_C;     hi = DMAXI;    end
            1:       begin lo = TH_L;     hi = TH_C - 1; end
            2:       begin lo = TH_H + 1; hi = TH_L - 1; end
            default: begin lo = 0;        hi = TH_H;     end
        endcase
        return (d >= lo - HY) && (d <= hi + HY);
    endfunction

    task automatic model_eval();
        int n = 0, mn = 1 << 30, mx = -1, cand;
        for (int i = 0; i < NS; i++)
            if (rd[i] > 0 && rd[i] != DMAXI && dl[i] <= TO) begin
                n++;
                if (rd[i] < mn) mn = rd[i];
                if (rd[i] > mx) mx = rd[i];
            end
        if (n == 0 || mx - mn > SPR) begin
            m_fault = 1;
        end else begin
            m_fault = 0;
            m_dist  = mn;
            cand    = in_band(m_class, m_dist) ? m_class : raw_cls(m_dist);
            if (cand == m_class) m_conf = 0;
            else begin
                m_conf++;
                if (m_conf == CF) begin
                    m_conf  = 0;
                    m_class = cand;
                    if (cand <= 1) m_valve = 1;
                    else if (cand == 3) m_valve = 0;
                end
            end
        end
    endtask

    task automatic set3(input int a, input int b, input int c);
        rd[0] = a; rd[1] = b; rd[2] = c;
        for (int i = 0; i < NS; i++) dl[i] = $urandom_range(1, 6);
    endtask

    // Serve one polling cycle; abort_ch < NS stops inside that channel's WAIT, drop_ini releases iniciar mid-cycle.
    task automatic run_cycle(input string tag, input int abort_ch, input bit drop_ini);
        int n;
        for (int ch = 0; ch < NS; ch++) begin
            n = 0;
            while (meas_start !== 1'b1 && n < PER + 50) begin tick(); n++; end
            chk($sformatf("%s_start%0d", tag, ch), 32'(meas_start), 1);
            if (meas_start !== 1'b1) return;
            chk($sformatf("%s_sel%0d", tag, ch), 32'(meas_sel), ch);
            if (ch == 0) begin
                if (prev_start >= 0) chk($sformatf("%s_period", tag), 32'(tcnt - prev_start), PER);
                prev_start = tcnt;
                if (drop_ini) iniciar = 1'b0;
            end
            if (ch == abort_ch) begin tick(); tick(); return; end
            if (rd[ch] >= 0) begin
                repeat (dl[ch]) tick();
                meas_done = 1'b1;
                meas_dist = DW'(rd[ch]);
                tick();
                meas_done = 1'b0;
                meas_dist = DW'($urandom);
            end else begin
                tick();
            end
        end
        n = 0;
        while (result_valid !== 1'b1 && n < 200) begin tick(); n++; end
        chk($sformatf("%s_rv", tag), 32'(result_valid), 1);
        model_eval();
        tick();
        tick();
        chk($sformatf("%s_dist", tag),  32'(level_dist),   m_dist);
        chk($sformatf("%s_class", tag), 32'(level_class),  m_class);
        chk($sformatf("%s_fault", tag), 32'(fault),        m_fault);
        chk($sformatf("%s_bzlo", tag),  32'(buzzer_baixa), (m_class == 0) ? 1 : 0);
        chk($sformatf("%s_bzhi", tag),  32'(buzzer_alta),  (m_class == 3) ? 1 : 0);
        chk($sformatf("%s_valve", tag), 32'(abre_valvula), (m_valve != 0 || manual_abre) ? 1 : 0);
        chk($sformatf("%s_state", tag), 32'(db_estado),    6);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_class"}, 32'(level_class), 2);
        chk({tag, "_dist"},  32'(level_dist), 0);
        chk({tag, "_valve"}, 32'(abre_valvula), 0);
        chk({tag, "_bzlo"},  32'(buzzer_baixa), 0);
        chk({tag, "_bzhi"},  32'(buzzer_alta), 0);
        chk({tag, "_fault"}, 32'(fault), 0);
        chk({tag, "_mstart"}, 32'(meas_start), 0);
        chk({tag, "_rv"},    32'(result_valid), 0);
        chk({tag, "_sel"},   32'(meas_sel), 0);
        chk({tag, "_state"}, 32'(db_estado), 0);
    endtask

    initial begin
        int n, seen, base;
        repeat (3) tick();
        chk_reset_vals("rst0");
        reset = 1'b1;
        repeat (5) tick();
        chk("idle_no_ini", 32'(db_estado), 0);
        iniciar = 1'b1;

        set3(300, 305, 310);    run_cycle("nom1", NS, 0);
        set3(300, 305, 310);    run_cycle("nom2", NS, 0);
        set3(300, -1, 302);     run_cycle("to1", NS, 0);
        set3(-1, -1, -1);       run_cycle("to_all", NS, 0);
        set3(320, 320, 320);    run_cycle("pre_spr", NS, 0);
        set3(300, 300, 350);    run_cycle("spread", NS, 0);
        set3(450, 455, 460);    run_cycle("crit1", NS, 0);
        set3(450, 455, 460);    run_cycle("crit2", NS, 0);
        for (int k = 0; k < 2; k++) begin set3(255, 256, 257); run_cycle("low", NS, 0); end
        for (int k = 0; k < 2; k++) begin set3(247, 248, 249); run_cycle("hyst_in", NS, 0); end
        for (int k = 0; k < 2; k++) begin set3(244, 245, 246); run_cycle("hyst_out", NS, 0); end
        for (int k = 0; k < 2; k++) begin set3(90, 92, 91); run_cycle("high", NS, 0); end
        set3(90, 92, 91); dl[0] = TO; run_cycle("coincide", NS, 0);
        set3(0, DMAXI, 93);     run_cycle("invalid", NS, 0);

        manual_abre = 1'b1;
        tick(); tick();
        chk("manual_on", 32'(abre_valvula), 1);
        manual_abre = 1'b0;
        tick(); tick();
        chk("manual_off", 32'(abre_valvula), m_valve);

        for (int k = 0; k < 20; k++) begin
            base = bases[$urandom_range(0, 9)] + $urandom_range(0, 8) - 4;
            for (int i = 0; i < NS; i++) begin
                rd[i] = base + $urandom_range(0, ($urandom_range(0, 3) == 0) ? 30 : 8);
                if ($urandom_range(0, 7) == 0) rd[i] = -1;
                else if ($urandom_range(0, 11) == 0) rd[i] = $urandom_range(0, 1) ? DMAXI : 0;
                dl[i] = $urandom_range(1, TO);
            end
            run_cycle($sformatf("rnd%0d", k), NS, 0);
        end

        set3(300, 301, 302);
        run_cycle("abort", 2, 0);
        reset = 1'b0;
        tick();
        chk_reset_vals("rst_mid");
        reset = 1'b1;
        m_class = 2; m_dist = 0; m_conf = 0; m_valve = 0; m_fault = 0;
        prev_start = -1;

        set3(120, 125, 130);    run_cycle("post_rst", NS, 0);
        set3(120, 125, 130);    run_cycle("drop_ini", NS, 1);
        n = 0;
        while (db_estado !== 4'd0 && n < PER + 20) begin tick(); n++; end
        chk("to_idle", 32'(db_estado), 0);
        seen = 0;
        repeat (30) begin tick(); if (meas_start === 1'b1) seen++; end
        chk("idle_quiet", 32'(seen), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/aqua_level_ctrl.md
AQUA_LEVEL_CTRL -- requirements
Module: aqua_level_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_SENS, 3: number of ultrasonic channels polled, 1..8.
- DW, 12: distance width in mm.
- TIMEOUT_CYC, 1500000: per-channel cycles allowed for meas_done.
- PERIOD_CYC, 50000000: cycles from cycle start to the next cycle start.
- SPREAD, 20: maximum allowed max-min among valid readings, mm.
- HYST, 5: hysteresis band, mm.
- CONFIRM, 2: consecutive agreeing evaluations needed before a class change, 1..15.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, in, 1: single clock.
- reset, in, 1: synchronous, active-low.
- iniciar, in, 1: level, enables continuous monitoring.
- manual_abre, in, 1: forces the valve open.
- th_crit / th_low / th_high, in, DW each: distance thresholds, th_high < th_low < th_crit.
- meas_start, out, 1: one-cycle request to the shared echo engine.
- meas_sel, out, clog2(N_SENS) (min 1): channel index under measurement.
- meas_done, in, 1: one-cycle completion strobe.
- meas_dist, in, DW: distance, valid with meas_done.
- level_dist, out, DW: aggregated distance of the last accepted cycle.
- level_class, out, 2: 00 CRIT, 01 LOW, 10 NORMAL, 11 HIGH.
- abre_valvula, out, 1: valve command.
- buzzer_baixa / buzzer_alta, out, 1 each: alarms.
- fault, out, 1: last cycle rejected.
- result_valid, out, 1: one-cycle pulse per completed evaluation.
- db_estado, out, 4: FSM state code.

Function
REQ-003 The block SHALL implement an FSM with these states and codes:
- IDLE 0, START 1, WAIT 2, NEXT 3, EVAL 4, CLASS 5, HOLD 6.

REQ-004 IDLE SHALL move to START when iniciar=1, clearing the channel index and the valid-reading accumulators (min, max, count).

REQ-005 START SHALL assert meas_start for exactly one cycle with meas_sel=index, and SHALL then enter WAIT with the timeout counter cleared.

REQ-006 WAIT handling:
- A sample SHALL be valid when meas_done=1 and meas_dist is neither 0 nor all-ones.
- A valid sample SHALL update min, max and count.
- meas_done SHALL exit to NEXT.
- The timeout counter reaching TIMEOUT_CYC-1 SHALL exit to NEXT with no sample recorded.
- If meas_done and timeout coincide, the sample SHALL be accepted.

REQ-007 meas_done outside WAIT SHALL be ignored.

REQ-008 NEXT SHALL go to START with index+1 if index<N_SENS-1, else to EVAL.

REQ-009 EVAL SHALL set fault=1 if count=0 or (max-min)>SPREAD, else fault=0 and level_dist=min; subtraction SHALL be unsigned in DW bits.

REQ-010 CLASS SHALL compute the raw class from d=level_dist:
- CRIT if d>=th_crit;
- else LOW if d>=th_low;
- else HIGH if d<=th_high;
- else NORMAL.

REQ-011 Hysteresis: the candidate SHALL equal the current class when d lies within the current class interval widened by HYST on both sides (saturating at 0 and 2^DW-1); otherwise the candidate SHALL equal the raw class.

REQ-012 Confirmation:
- When candidate differs from the current class, a confirm counter SHALL increment.
- When the counter reaches CONFIRM, level_class SHALL take the candidate and the counter SHALL clear.
- The counter SHALL clear whenever candidate equals the current class.

REQ-013 On fault, CLASS SHALL leave level_class, level_dist and the confirm counter unchanged.

REQ-014 result_valid SHALL pulse in the CLASS cycle, and the FSM SHALL then enter HOLD.

REQ-015 HOLD exit:
- HOLD SHALL wait until the cycle counter, started on leaving IDLE, reaches PERIOD_CYC-1.
- It SHALL then go to START if iniciar=1, else to IDLE.
- If the cycle already exceeded PERIOD_CYC, HOLD SHALL last exactly one cycle.

REQ-016 iniciar deassertion SHALL NOT abort a cycle in progress.

REQ-017 The valve auto-state register:
- SHALL set when level_class becomes CRIT or LOW;
- SHALL clear when it becomes HIGH;
- SHALL hold in NORMAL and on fault.

REQ-018 Outputs SHALL be registered:
- abre_valvula = auto-state OR manual_abre, with one cycle latency.
- buzzer_baixa = (level_class==CRIT).
- buzzer_alta = (level_class==HIGH).

Reset
REQ-019 With reset=0 at a clock edge, the FSM SHALL go to IDLE, including mid-measurement, and all counters and accumulators SHALL clear.

REQ-020 Reset values SHALL be:
- level_class=10, level_dist=0;
- abre_valvula, buzzers, fault, meas_start, result_valid, meas_sel = 0;
- db_estado=0.

Verification
REQ-021 N_SENS=3, distances 300/305/310, th 400/250/100, CONFIRM=2 -> two cycles: level_dist=300, level_class=10, no alarms.

REQ-022 Distances 450/455/460 for two cycles -> class 10 after cycle 1, 00 after cycle 2; buzzer_baixa=1 and abre_valvula=1.

REQ-023 Channel 1 never answers (timeout), others 300/302 -> level_dist=300, fault=0; all three time out -> fault=1, class unchanged.

REQ-024 Readings 300/300/350 -> fault=1 (spread 50>20); level_dist retains its prior value.

REQ-025 LOW at d=255, then d=247 for two cycles (HYST=5) -> remains LOW; then d=244 for two cycles -> becomes NORMAL.

REQ-026 Reset=0 asserted during WAIT of channel 2 -> next edge: db_estado=0, meas_start=0, outputs at reset values.
